// File: rtl/snd_mix_pkg.sv
// snd_mix_pkg
//   Shared constants, FSM state type and the output saturation helper for
//   the time-multiplexed audio mixer (snd_mix_sched / snd_mix_mac).
package snd_mix_pkg;

  localparam int VOL_UNITY  = 256;  // volume code for gain 1.0
  localparam int SMP_W      = 16;   // signed source / output sample width
  localparam int FRAC_SHIFT = 8;    // volume has 8 fractional bits
  localparam int SAT_IN_W   = 40;   // common width fed to the saturator

  // Signed product width for a 16-bit sample times an unsigned volume.
  function automatic int prod_width(input int vol_w);
    return SMP_W + vol_w;
  endfunction

  // Accumulator width: product plus headroom for summing src_num products.
  function automatic int acc_width(input int vol_w, input int src_num);
    return SMP_W + vol_w + $clog2(src_num);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic             clip;
    logic [SMP_W-1:0] val;
  } sat_t;

  localparam logic signed [SAT_IN_W-1:0] SAT_MAX = 40'sd32767;
  localparam logic signed [SAT_IN_W-1:0] SAT_MIN = -40'sd32768;

  // Clamp a wide signed value into the 16-bit output range and flag clipping.
  function automatic sat_t saturate16(input logic signed [SAT_IN_W-1:0] v);
    sat_t r;
    r.clip = 1'b0;
    r.val  = v[SMP_W-1:0];
    if (v > SAT_MAX) begin
      r.clip = 1'b1;
      r.val  = 16'h7FFF;
    end else if (v < SAT_MIN) begin
      r.clip = 1'b1;
      r.val  = 16'h8000;
    end
    return r;
  endfunction

endpackage

// File: rtl/snd_mix_mac.sv
// snd_mix_mac
//   Shared multiply-accumulate for the mixer: one signed x unsigned
//   multiplier feeding a left and a right accumulator, followed by the
//   floor shift and saturation stage for both sides.
// Ports:
//   clk, rst        clock (falling-edge active), synchronous active-high reset
//   i_clr           clear both accumulators (start of frame)
//   i_acc_en        add the current product into the side chosen by i_side
//   i_side          0 = left accumulator, 1 = right accumulator
//   i_smp           signed 16-bit sample operand
//   i_vol           unsigned volume operand
//   o_out_l/o_out_r saturated 16-bit results of both accumulators
//   o_clip_l/_r     saturation flags of both results
module snd_mix_mac
  import snd_mix_pkg::*;
#(
  parameter int VOL_W = 9,
  parameter int ACC_W = 27
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clr,
  input  logic                    i_acc_en,
  input  logic                    i_side,
  input  logic signed [SMP_W-1:0] i_smp,
  input  logic [VOL_W-1:0]        i_vol,
  output logic signed [SMP_W-1:0] o_out_l,
  output logic signed [SMP_W-1:0] o_out_r,
  output logic                    o_clip_l,
  output logic                    o_clip_r
);

  // One extra bit so the unsigned volume can be treated as a positive signed value.
  localparam int MUL_W = prod_width(VOL_W) + 1;

  logic signed [MUL_W-1:0] w_smp_x;
  logic signed [MUL_W-1:0] w_vol_x;
  logic signed [MUL_W-1:0] w_prod;
  logic signed [ACC_W-1:0] w_prod_x;
  logic signed [ACC_W-1:0] r_acc_l;
  logic signed [ACC_W-1:0] r_acc_r;
  logic signed [ACC_W-1:0] w_sh_l;
  logic signed [ACC_W-1:0] w_sh_r;
  sat_t                    w_sat_l;
  sat_t                    w_sat_r;

  assign w_smp_x  = MUL_W'(i_smp);
  assign w_vol_x  = $signed(MUL_W'(i_vol));
  assign w_prod   = w_smp_x * w_vol_x;
  assign w_prod_x = ACC_W'(w_prod);

  always_ff @(negedge clk) begin
    if (rst || i_clr) begin
      r_acc_l <= '0;
      r_acc_r <= '0;
    end else if (i_acc_en) begin
      if (i_side) begin
        r_acc_r <= r_acc_r + w_prod_x;
      end else begin
        r_acc_l <= r_acc_l + w_prod_x;
      end
    end
  end

  // Arithmetic shift gives floor rounding for negative sums.
  assign w_sh_l  = r_acc_l >>> FRAC_SHIFT;
  assign w_sh_r  = r_acc_r >>> FRAC_SHIFT;
  assign w_sat_l = saturate16(SAT_IN_W'(w_sh_l));
  assign w_sat_r = saturate16(SAT_IN_W'(w_sh_r));

  assign o_out_l  = w_sat_l.val;
  assign o_out_r  = w_sat_r.val;
  assign o_clip_l = w_sat_l.clip;
  assign o_clip_r = w_sat_r.clip;

endmodule

// File: rtl/snd_mix_sched.sv
// snd_mix_sched
//   Time-multiplexed stereo mixer. Each accepted next_sample strobe starts a
//   fixed-length frame: all sources are snapshotted, then run through the
//   shared MAC (left then right per source), and the saturated sums are
//   registered onto snd_l/snd_r.
// Ports:
//   clk, rst         clock (falling-edge active), synchronous active-high reset
//   next_sample      frame strobe from the DAC
//   src_l/src_r      signed 16-bit samples, one per source
//   src_en           per-source enable
//   cfg_we/addr/data volume write; addr bit0 = side, upper bits = source
//   snd_l/snd_r      mixed outputs, held between frames
//   busy             frame in progress
//   ovr              one-cycle pulse when a strobe arrives while busy
//   clip             one-cycle pulse when a frame result saturated
module snd_mix_sched
  import snd_mix_pkg::*;
#(
  parameter int SRC_NUM = 4,
  parameter int VOL_W   = 9
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                next_sample,
  input  logic [SRC_NUM-1:0][SMP_W-1:0]       src_l,
  input  logic [SRC_NUM-1:0][SMP_W-1:0]       src_r,
  input  logic [SRC_NUM-1:0]                  src_en,
  input  logic                                cfg_we,
  input  logic [$clog2(SRC_NUM):0]            cfg_addr,
  input  logic [VOL_W-1:0]                    cfg_data,
  output logic signed [SMP_W-1:0]             snd_l,
  output logic signed [SMP_W-1:0]             snd_r,
  output logic                                busy,
  output logic                                ovr,
  output logic                                clip
);

  localparam int ADDR_W = $clog2(SRC_NUM) + 1;
  localparam int VOL_N  = 2 * SRC_NUM;
  localparam int ACC_W  = acc_width(VOL_W, SRC_NUM);
  localparam logic [ADDR_W-1:0] LAST_STEP = ADDR_W'(VOL_N - 1);
  localparam logic [VOL_W-1:0]  VOL_MAX   = VOL_W'(VOL_UNITY);

  state_t                    r_state;
  state_t                    w_state_next;
  logic [ADDR_W-1:0]         r_step;
  logic [SMP_W-1:0]          r_snap_l [SRC_NUM];
  logic [SMP_W-1:0]          r_snap_r [SRC_NUM];
  logic [VOL_W-1:0]          r_vol [VOL_N];
  logic                      r_pend_vld;
  logic [ADDR_W-1:0]         r_pend_addr;
  logic [VOL_W-1:0]          r_pend_data;
  logic signed [SMP_W-1:0]   r_snd_l;
  logic signed [SMP_W-1:0]   r_snd_r;
  logic                      r_ovr;
  logic                      r_clip;

  logic                      w_mac_clr;
  logic                      w_mac_en;
  logic                      w_side;
  logic [ADDR_W-2:0]         w_src_idx;
  logic signed [SMP_W-1:0]   w_mac_smp;
  logic signed [SMP_W-1:0]   w_mix_l;
  logic signed [SMP_W-1:0]   w_mix_r;
  logic                      w_clip_l;
  logic                      w_clip_r;
  logic [VOL_W-1:0]          w_cfg_vol;
  logic                      w_cfg_hit;
  logic [SRC_NUM-1:0][SMP_W-1:0] w_gate_l;
  logic [SRC_NUM-1:0][SMP_W-1:0] w_gate_r;

  // Disabled sources are zeroed at snapshot time, so they add nothing but
  // still occupy their two MAC steps and the frame length stays fixed.
  for (genvar gi = 0; gi < SRC_NUM; gi++) begin : g_gate
    assign w_gate_l[gi] = src_en[gi] ? src_l[gi] : '0;
    assign w_gate_r[gi] = src_en[gi] ? src_r[gi] : '0;
  end

  // Volume writes above unity are clamped to unity.
  assign w_cfg_vol = (cfg_data > VOL_MAX) ? VOL_MAX : cfg_data;
  assign w_cfg_hit = cfg_we && ({1'b0, cfg_addr} < (ADDR_W + 1)'(VOL_N));

  // Step counter doubles as the volume-file address: {source, side}.
  assign w_side    = r_step[0];
  assign w_src_idx = r_step[ADDR_W-1:1];
  assign w_mac_smp = w_side ? $signed(r_snap_r[w_src_idx]) : $signed(r_snap_l[w_src_idx]);

  always_comb begin
    w_state_next = r_state;
    w_mac_clr    = 1'b0;
    w_mac_en     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (next_sample) begin
          w_mac_clr    = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        w_mac_en = 1'b1;
        if (r_step == LAST_STEP) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_step      <= '0;
      r_snd_l     <= '0;
      r_snd_r     <= '0;
      r_ovr       <= 1'b0;
      r_clip      <= 1'b0;
      r_pend_vld  <= 1'b0;
      r_pend_addr <= '0;
      r_pend_data <= '0;
      for (int i = 0; i < VOL_N; i++) begin
        r_vol[i] <= VOL_MAX;
      end
    end else begin
      r_state <= w_state_next;
      r_ovr   <= next_sample && (r_state != ST_IDLE);
      r_clip  <= 1'b0;

      if (w_mac_clr) begin
        r_step <= '0;
        for (int i = 0; i < SRC_NUM; i++) begin
          r_snap_l[i] <= w_gate_l[i];
          r_snap_r[i] <= w_gate_r[i];
        end
      end else if (r_state == ST_RUN) begin
        r_step <= r_step + 1'b1;
      end

      if (r_state == ST_DONE) begin
        r_snd_l    <= w_mix_l;
        r_snd_r    <= w_mix_r;
        r_clip     <= w_clip_l | w_clip_r;
        r_pend_vld <= 1'b0;
        // A write arriving on the final frame cycle is the newest one and
        // therefore replaces whatever was pending.
        if (w_cfg_hit) begin
          r_vol[cfg_addr] <= w_cfg_vol;
        end else if (r_pend_vld) begin
          r_vol[r_pend_addr] <= r_pend_data;
        end
      end else if (w_cfg_hit) begin
        if (r_state == ST_RUN) begin
          // Keep volumes stable for the running frame; last write wins.
          r_pend_vld  <= 1'b1;
          r_pend_addr <= cfg_addr;
          r_pend_data <= w_cfg_vol;
        end else begin
          r_vol[cfg_addr] <= w_cfg_vol;
        end
      end
    end
  end

  snd_mix_mac #(
    .VOL_W (VOL_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_mac_clr),
    .i_acc_en (w_mac_en),
    .i_side   (w_side),
    .i_smp    (w_mac_smp),
    .i_vol    (r_vol[r_step]),
    .o_out_l  (w_mix_l),
    .o_out_r  (w_mix_r),
    .o_clip_l (w_clip_l),
    .o_clip_r (w_clip_r)
  );

  assign snd_l = r_snd_l;
  assign snd_r = r_snd_r;
  assign busy  = (r_state != ST_IDLE);
  assign ovr   = r_ovr;
  assign clip  = r_clip;

endmodule

// File: tb/tb_snd_mix_sched.sv
// tb_snd_mix_sched
//   Directed bench for snd_mix_sched (SRC_NUM = 4). A frame-level model
//   computes each frame's mix with plain integer arithmetic when the strobe
//   is accepted and releases it 2N+1 edges later; a compare process checks
//   every DUT output against it each cycle. Literal checks pin the model.
module tb_snd_mix_sched;

  localparam int N     = 4;
  localparam int FRAME = 2 * N + 1;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    next_sample;
  logic [N-1:0][15:0]      src_l;
  logic [N-1:0][15:0]      src_r;
  logic [N-1:0]            src_en;
  logic                    cfg_we;
  logic [$clog2(N):0]      cfg_addr;
  logic [8:0]              cfg_data;
  logic signed [15:0]      snd_l;
  logic signed [15:0]      snd_r;
  logic                    busy;
  logic                    ovr;
  logic                    clip;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  snd_mix_sched #(.SRC_NUM(N), .VOL_W(9)) dut (
    .clk         (clk),
    .rst         (rst),
    .next_sample (next_sample),
    .src_l       (src_l),
    .src_r       (src_r),
    .src_en      (src_en),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .snd_l       (snd_l),
    .snd_r       (snd_r),
    .busy        (busy),
    .ovr         (ovr),
    .clip        (clip)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int clampv(input int d);
    return (d > 256) ? 256 : d;
  endfunction

  // ---------------- frame-level model ----------------
  int     m_vol [2*N];
  int     m_rem = 0;
  longint m_res_l, m_res_r;
  bit     m_res_clip;
  bit     m_pend;
  int     m_pa, m_pd;
  longint e_l = 0, e_r = 0;
  bit     e_busy = 0, e_ovr = 0, e_clip = 0;
  bit     m_valid = 0;

  always @(negedge clk) begin : model
    longint sl, sr;
    if (rst) begin
      for (int i = 0; i < 2*N; i++) m_vol[i] = 256;
      m_rem = 0; m_pend = 0;
      e_l = 0; e_r = 0; e_busy = 0; e_ovr = 0; e_clip = 0;
      m_valid = 1;
    end else if (m_valid) begin
      e_ovr = 0;
      e_clip = 0;
      if (m_rem > 0) begin
        if (next_sample) e_ovr = 1;
        if (cfg_we) begin
          m_pend = 1; m_pa = int'(cfg_addr); m_pd = clampv(int'(cfg_data));
        end
        m_rem--;
        if (m_rem == 0) begin
          e_l = m_res_l; e_r = m_res_r; e_clip = m_res_clip;
          if (m_pend) m_vol[m_pa] = m_pd;
          m_pend = 0;
        end
      end else begin
        if (cfg_we) m_vol[int'(cfg_addr)] = clampv(int'(cfg_data));
        if (next_sample) begin
          sl = 0; sr = 0;
          for (int i = 0; i < N; i++) begin
            if (src_en[i]) begin
              sl += longint'($signed(src_l[i])) * m_vol[2*i];
              sr += longint'($signed(src_r[i])) * m_vol[2*i+1];
            end
          end
          sl = sl >>> 8;
          sr = sr >>> 8;
          m_res_clip = (sl > 32767) || (sl < -32768) || (sr > 32767) || (sr < -32768);
          m_res_l = (sl > 32767) ? 32767 : ((sl < -32768) ? -32768 : sl);
          m_res_r = (sr > 32767) ? 32767 : ((sr < -32768) ? -32768 : sr);
          m_rem = FRAME;
        end
      end
      e_busy = (m_rem > 0);
    end
  end

  // Outputs change on the falling edge; sample them on the rising edge.
  always @(posedge clk) begin
    if (m_valid) begin
      chk("cyc_snd_l", snd_l, e_l);
      chk("cyc_snd_r", snd_r, e_r);
      chk("cyc_busy", busy, longint'(e_busy));
      chk("cyc_ovr", ovr, longint'(e_ovr));
      chk("cyc_clip", clip, longint'(e_clip));
    end
  end

  // ---------------- stimulus ----------------
  // Called right after a rising edge. Strobe lands on E0; an extra strobe is
  // raised so it is sampled on E(rej_at) (0 = none). Counts busy/ovr/clip
  // cycles over a window that covers the whole frame plus margin.
  task automatic run_frame(input int rej_at, output int nb, output int no, output int nc);
    nb = 0; no = 0; nc = 0;
    next_sample = 1'b1;
    for (int p = 0; p < 14; p++) begin
      @(posedge clk);
      next_sample = (p + 1 == rej_at);
      if (busy) nb++;
      if (ovr)  no++;
      if (clip) nc++;
    end
    next_sample = 1'b0;
  endtask

  task automatic cfg_write(input int a, input int d);
    cfg_we   = 1'b1;
    cfg_addr = 3'(a);
    cfg_data = 9'(d);
    @(posedge clk);
    cfg_we   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    rst = 1'b0;
    @(posedge clk);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int nb, no, nc;
    rst = 1'b1; next_sample = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    src_l = '0; src_r = '0; src_en = '1;
    @(posedge clk);
    next_sample = 1'b1;           // coincident with reset: must be ignored
    src_l[0] = 16'd5;
    @(posedge clk);
    next_sample = 1'b0;
    @(posedge clk);
    rst = 1'b0;
    @(posedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_snd_l", snd_l, 0);
    chk("reset_snd_r", snd_r, 0);
    chk("reset_ovr", ovr, 0);

    // Single source at unity
    src_l = '0; src_r = '0;
    src_l[0] = 16'd1000;
    run_frame(0, nb, no, nc);
    chk("single_busy_cycles", nb, 9);
    chk("single_snd_l", snd_l, 1000);
    chk("single_snd_r", snd_r, 0);
    chk("single_ovr_cnt", no, 0);

    // Volume scaling with floor rounding, then clamp of oversize volume
    src_l = '0;
    src_l[1] = -16'sd1001;
    cfg_write(2, 128);
    run_frame(0, nb, no, nc);
    chk("vol128_snd_l", snd_l, -501);
    cfg_write(2, 300);
    run_frame(0, nb, no, nc);
    chk("vol300_snd_l", snd_l, -1001);
    src_r[2] = 16'd999;
    cfg_write(5, 64);
    run_frame(0, nb, no, nc);
    chk("volr64_snd_r", snd_r, 249);

    // Saturation and its boundaries
    do_reset();
    for (int i = 0; i < N; i++) begin
      src_l[i] = 16'd30000;
      src_r[i] = -16'sd30000;
    end
    run_frame(0, nb, no, nc);
    chk("sat_snd_l", snd_l, 32767);
    chk("sat_snd_r", snd_r, -32768);
    chk("sat_clip_cnt", nc, 1);
    src_l = '0; src_r = '0;
    src_l[0] = 16'h7FFF;
    src_r[3] = 16'h8000;
    run_frame(0, nb, no, nc);
    chk("edge_snd_l", snd_l, 32767);
    chk("edge_snd_r", snd_r, -32768);
    chk("edge_clip_cnt", nc, 0);
    src_l[1] = 16'd1;
    run_frame(0, nb, no, nc);
    chk("edge1_snd_l", snd_l, 32767);
    chk("edge1_clip_cnt", nc, 1);

    // Rejected strobe at E3, inputs changed mid-frame
    src_l = '0; src_r = '0;
    src_l[0] = 16'd1234;
    src_r[1] = -16'sd55;
    fork
      run_frame(3, nb, no, nc);
      begin
        @(posedge clk);
        @(posedge clk);
        src_l[0] = -16'sd7;
        src_r[1] = 16'd7;
      end
    join
    chk("rej_busy_cycles", nb, 9);
    chk("rej_ovr_cnt", no, 1);
    chk("rej_snd_l", snd_l, 1234);
    chk("rej_snd_r", snd_r, -55);
    run_frame(0, nb, no, nc);
    chk("after_rej_snd_l", snd_l, -7);
    chk("after_rej_snd_r", snd_r, 7);

    // Pending volume write during a frame, last-write-wins
    src_l = '0; src_r = '0;
    src_l[0] = 16'd1000;
    fork
      run_frame(0, nb, no, nc);
      begin
        repeat (2) @(posedge clk);
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 9'd0;
        @(posedge clk);
        cfg_we = 1'b0;
      end
    join
    chk("pend_cur_snd_l", snd_l, 1000);
    fork
      run_frame(0, nb, no, nc);
      begin
        repeat (2) @(posedge clk);
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 9'd64;
        @(posedge clk);
        cfg_data = 9'd128;
        @(posedge clk);
        cfg_we = 1'b0;
      end
    join
    chk("pend_next_snd_l", snd_l, 0);
    run_frame(0, nb, no, nc);
    chk("pend_last_wins_snd_l", snd_l, 500);
    cfg_write(0, 256);

    // Disabled source still takes its slots
    src_en = 4'b1110;
    src_l[1] = 16'd200;
    run_frame(0, nb, no, nc);
    chk("en_busy_cycles", nb, 9);
    chk("en_snd_l", snd_l, 200);
    src_en = '1;

    // Reset mid-frame with a write pending
    src_l = '0;
    src_l[0] = 16'd1000;
    next_sample = 1'b1;
    @(posedge clk);
    next_sample = 1'b0;
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 9'd0;
    @(posedge clk);
    cfg_we = 1'b0;
    @(posedge clk);
    @(posedge clk);
    rst = 1'b1;
    @(posedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_snd_l", snd_l, 0);
    chk("midrst_snd_r", snd_r, 0);
    rst = 1'b0;
    run_frame(0, nb, no, nc);
    chk("midrst_next_snd_l", snd_l, 1000);
    chk("midrst_busy_cycles", nb, 9);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/snd_mix_sched.md
# snd_mix_sched

Time-multiplexed audio mixer and scheduler that sits between the sound sources (FM, PSG, PCM, CDDA) and `audio_ed`'s DAC path. Each DAC `next_sample` strobe triggers one fixed-length mixing frame. The frame snapshots every source, then runs them in sequence through one shared multiply-accumulate with per-source, per-side volume. It saturates the sums and drives the stereo `snd_l`/`snd_r` pair that feeds the DAC bus.

## Interface
Parameters:
- `SRC_NUM`, 4: number of mixed sources (2..8).
- `VOL_W`, 9: volume width; unsigned, 256 = unity.

Ports:
- `clk` in 1: system clock; all flops update on falling edge, matching the DAC path.
- `rst` in 1: reset, synchronous, active-high.
- `next_sample` in 1: one-cycle frame strobe from the DAC.
- `src_l` in `SRC_NUM`×16: signed left samples, one per source.
- `src_r` in `SRC_NUM`×16: signed right samples, one per source.
- `src_en` in `SRC_NUM`: per-source enable.
- `cfg_we` in 1: volume write strobe.
- `cfg_addr` in `$clog2(SRC_NUM)+1`: bit0 = side (0 = L, 1 = R); upper bits = source index.
- `cfg_data` in `VOL_W`: volume value.
- `snd_l` out 16: signed mixed left output.
- `snd_r` out 16: signed mixed right output.
- `busy` out 1: frame in progress.
- `ovr` out 1: one-cycle pulse, strobe lost.
- `clip` out 1: one-cycle pulse, saturation occurred in the frame.

## Operation
- States: IDLE, RUN, DONE.
- Volume registers:
  - 2×`SRC_NUM` registers.
  - Reset value 256.
  - Writes of values above 256 store 256.
- IDLE, on `next_sample`:
  - Snapshot `src_l`, `src_r` and `src_en`.
  - Clear `acc_l` and `acc_r`.
  - Set index to 0 and enter RUN.
- RUN:
  - Step counter 0..2·`SRC_NUM`−1.
  - Even step: `acc_l += snap_l[i]·vol_l[i]`.
  - Odd step: `acc_r += snap_r[i]·vol_r[i]`, then `i++`.
  - A disabled source adds 0 but still consumes its two steps, so frame length is fixed.
  - Enter DONE after the last step.
- Arithmetic:
  - Product is 16s × 9u, 25 bits signed.
  - Accumulator is 25+`$clog2(SRC_NUM)` bits signed.
  - Result = arithmetic shift right by 8 (floor), then saturate to [−32768, 32767].
- DONE:
  - Register `snd_l` and `snd_r`.
  - Pulse `clip` if either side saturated.
  - Apply the pending volume write.
  - Return to IDLE.
- Config writes:
  - In IDLE, a write takes effect at the next edge.
  - While busy, the write goes to a one-entry pending register; a later write overwrites it (last wins).
  - Pending is applied at DONE, so the current frame always uses stable volumes.
- `next_sample` while busy: ignored (no restart, no snapshot); `ovr` pulses for one cycle.
- `rst`, including mid-frame:
  - State goes to IDLE.
  - `snd_l` = `snd_r` = 0; `busy`, `ovr` and `clip` = 0.
  - Pending write is dropped; all volumes return to 256.
- `next_sample` coincident with `rst`: ignored.

## Timing
- Strobe sampled at edge E0: state becomes RUN and `busy` = 1 after E0.
- MAC steps run on E1..E(2N); DONE is entered at E(2N).
- Outputs update at E(2N+1), where `busy` falls. Latency is 2N+1 cycles (9 for N = 4).
- A new strobe is accepted from the cycle after E(2N+1). Required strobe spacing is at least 2N+2 cycles; the DAC provides 512.
- `clip` is high for the cycle after E(2N+1). `ovr` is high for the cycle after the rejected strobe edge.
- Outputs hold between frames.

## Structure
- Package `snd_mix_pkg` holds:
  - `VOL_UNITY` = 256.
  - Sample, product and accumulator width constants.
  - The state enum.
  - The saturate function.
- Sub-module `snd_mix_mac` is the shared multiplier, accumulator pair and saturation stage. It takes a side select, a clear and an accumulate enable.
- Top level holds the FSM, snapshot registers, volume file and pending-write logic.

## Test plan
- **Single source:** after reset, src0 L = 1000, all others 0, all enabled, one strobe. Required: `snd_l` = 1000 and `snd_r` = 0 at E9; `busy` high for exactly 9 cycles.
- **Volume scaling and floor rounding:** `vol_l[1]` = 128, src1 L = −1001. Required: `snd_l` = −501. Then write 300 to `vol_l[1]` and read back via mix; it must behave as 256.
- **Saturation:** all 4 L = 30000 and all 4 R = −30000, unity volume. Required: `snd_l` = 32767, `snd_r` = −32768, `clip` pulses once.
- **Rejected strobe:** second strobe at E3. Required: `ovr` pulses one cycle; frame completes at E9 with first-frame values; no restart.
- **Pending volume and enable:** during a frame, write `vol_l[0]` = 0 with src0 L = 1000. Required: current frame outputs 1000; next frame outputs 0. Separately, `src_en[0]` = 0 → contribution 0 and latency still 9.
- **Reset mid-frame:** assert `rst` at E4 with a write pending. Required: at the next edge outputs = 0, `busy` = 0; the pending write is lost; the next frame uses volume 256.
